// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and FSM encoding for the data memory responder.
package mem_map_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_8000;

    // Byte offsets inside the 4-word MMIO window
    localparam logic [3:0] MMIO_OFF_CYC     = 4'h0;
    localparam logic [3:0] MMIO_OFF_STORES  = 4'h4;
    localparam logic [3:0] MMIO_OFF_SCRATCH = 4'h8;
    localparam logic [3:0] MMIO_OFF_TOHOST  = 4'hC;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data RAM: asynchronous read, synchronous write, no reset.
// Ports:
//   clka      - write clock
//   i_we      - write enable
//   i_addr    - word address (shared by read and write)
//   i_wdata   - write data
//   o_rdata   - combinational read data (pre-write value during a write cycle)
module dmem_ram
    import mem_map_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clka,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage is intentionally not reset so contents survive a register reset
    always_ff @(posedge clka) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for a CPU MEM stage: RAM plus a small MMIO window
// (cycle counter, store counter, scratch, tohost) with a RUN/HALT FSM.
// Ports:
//   clka         - clock
//   rst          - asynchronous active-high reset (registers only, not RAM)
//   memwrite     - store strobe
//   addr         - byte address
//   writedata    - store data
//   readdata     - combinational load data
//   done         - set once tohost has been written
//   tohost       - value captured by the halting store
//   misalign_err - sticky misaligned-store flag
//   err_addr     - address of the first misaligned store
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        done,
    output logic [31:0] tohost,
    output logic        misalign_err,
    output logic [31:0] err_addr
);

    state_t      r_state;
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_st_cnt;
    logic [31:0] r_scratch;
    logic [31:0] r_tohost;
    logic        r_done;
    logic        r_misalign;
    logic [31:0] r_err_addr;

    logic        w_ram_sel;
    logic        w_mmio_sel;
    logic [3:0]  w_mmio_off;
    logic        w_aligned;
    logic        w_store_ok;
    logic        w_ram_we;
    logic        w_scratch_we;
    logic        w_tohost_we;
    logic        w_count_store;
    logic        w_misalign;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_mmio_rdata;

    // Address decode; RAM wins if a parameter choice ever overlaps the window
    assign w_ram_sel  = ((addr >> (ADDR_W + 2)) == 32'd0);
    assign w_mmio_sel = !w_ram_sel && (addr[31:4] == MMIO_BASE[31:4]);
    assign w_mmio_off = {addr[3:2], 2'b00};
    assign w_aligned  = (addr[1:0] == 2'b00);

    // Store acceptance; rst gating keeps a coincident store out of the RAM
    assign w_store_ok    = memwrite && !rst && (r_state == ST_RUN) && w_aligned;
    assign w_ram_we      = w_store_ok && w_ram_sel;
    assign w_scratch_we  = w_store_ok && w_mmio_sel && (w_mmio_off == MMIO_OFF_SCRATCH);
    assign w_tohost_we   = w_store_ok && w_mmio_sel && (w_mmio_off == MMIO_OFF_TOHOST);
    assign w_count_store = w_ram_we || w_scratch_we || w_tohost_we;
    assign w_misalign    = memwrite && (r_state == ST_RUN) && !w_aligned;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clka    (clka),
        .i_we    (w_ram_we),
        .i_addr  (addr[ADDR_W+1:2]),
        .i_wdata (writedata),
        .o_rdata (w_ram_rdata)
    );

    // MMIO read mux
    always_comb begin
        w_mmio_rdata = 32'd0;
        unique case (w_mmio_off)
            MMIO_OFF_CYC:     w_mmio_rdata = r_cyc_cnt;
            MMIO_OFF_STORES:  w_mmio_rdata = r_st_cnt;
            MMIO_OFF_SCRATCH: w_mmio_rdata = r_scratch;
            MMIO_OFF_TOHOST:  w_mmio_rdata = {31'd0, r_done};
            default:          w_mmio_rdata = 32'd0;
        endcase
    end

    assign readdata = w_ram_sel  ? w_ram_rdata  :
                      w_mmio_sel ? w_mmio_rdata : 32'd0;

    // FSM, counters and MMIO registers
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_cyc_cnt  <= 32'd0;
            r_st_cnt   <= 32'd0;
            r_scratch  <= 32'd0;
            r_tohost   <= 32'd0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_err_addr <= 32'd0;
        end else begin
            if (r_state == ST_RUN) begin
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            end
            if (w_count_store) begin
                r_st_cnt <= r_st_cnt + 32'd1;
            end
            if (w_scratch_we) begin
                r_scratch <= writedata;
            end
            // Only the first misaligned address is kept
            if (w_misalign) begin
                r_misalign <= 1'b1;
                if (!r_misalign) begin
                    r_err_addr <= addr;
                end
            end
            if (r_state == ST_RUN) begin
                if (w_tohost_we) begin
                    r_tohost <= writedata;
                    r_done   <= 1'b1;
                    r_state  <= ST_HALT;
                end
            end
        end
    end

    assign done         = r_done;
    assign tohost       = r_tohost;
    assign misalign_err = r_misalign;
    assign err_addr     = r_err_addr;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

    localparam logic [31:0] MMIO = 32'h0000_8000;

    logic        clka;
    logic        rst;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        done;
    logic [31:0] tohost;
    logic        misalign_err;
    logic [31:0] err_addr;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_cyc;
    bit          m_halt;

    data_mem_responder #(
        .ADDR_W    (8),
        .MMIO_BASE (MMIO)
    ) dut (
        .clka         (clka),
        .rst          (rst),
        .memwrite     (memwrite),
        .addr         (addr),
        .writedata    (writedata),
        .readdata     (readdata),
        .done         (done),
        .tohost       (tohost),
        .misalign_err (misalign_err),
        .err_addr     (err_addr)
    );

    initial clka = 1'b0;
    always #10 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock; the model cycle counter follows the RUN-state rule
    task automatic tick();
        @(posedge clka);
        if (!rst && !m_halt) exp_cyc = exp_cyc + 32'd1;
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_cyc   = 32'd0;
        m_halt    = 1'b0;
        rst       = 1'b1;
        memwrite  = 1'b0;
        addr      = 32'd0;
        writedata = 32'd0;
        tick();
        tick();

        // Reset state
        check("rst_done", 32'(done), 32'd0);
        check("rst_tohost", tohost, 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_err_addr", err_addr, 32'd0);

        // Cycle counter: 100 clocks after reset release, then forced wrap
        rst = 1'b0;
        repeat (100) tick();
        load_check("cyc_100", MMIO, 32'd100);
        force dut.r_cyc_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_cyc_cnt;
        load_check("cyc_preload", MMIO, 32'hFFFF_FFFF);
        tick();
        load_check("cyc_wrap", MMIO, 32'd0);
        exp_cyc = 32'd0;

        // RAM store/load and same-cycle read-before-write
        store(32'h10, 32'h1111_1111);
        store(32'h00, 32'hA5A5_A5A5);
        addr      = 32'h10;
        writedata = 32'hDEAD_BEEF;
        memwrite  = 1'b1;
        #1;
        check("ram_same_cycle_old", readdata, 32'h1111_1111);
        tick();
        memwrite = 1'b0;
        load_check("ram_new_value", 32'h10, 32'hDEAD_BEEF);
        load_check("ram_ignores_low_bits", 32'h13, 32'hDEAD_BEEF);
        load_check("st_cnt_3", MMIO + 32'h4, 32'd3);

        // Misaligned stores: sticky flag, first address kept, nothing written
        store(32'h13, 32'hBAD0_BAD0);
        check("misalign_set", 32'(misalign_err), 32'd1);
        check("err_addr_first", err_addr, 32'h13);
        store(32'h21, 32'h1234_5678);
        check("err_addr_kept", err_addr, 32'h13);
        load_check("ram_unchanged", 32'h10, 32'hDEAD_BEEF);
        load_check("st_cnt_misalign", MMIO + 32'h4, 32'd3);
        load_check("cyc_running", MMIO, exp_cyc);

        // RO offset and unmapped stores are dropped
        store(MMIO, 32'h0000_0077);
        store(32'h0001_0000, 32'h0000_0099);
        load_check("st_cnt_dropped", MMIO + 32'h4, 32'd3);
        load_check("unmapped_zero", 32'h0001_0000, 32'd0);
        load_check("cyc_not_written", MMIO, exp_cyc);

        // Scratch read/write
        store(MMIO + 32'h8, 32'hCAFE_0001);
        load_check("scratch_rw", MMIO + 32'h8, 32'hCAFE_0001);
        load_check("st_cnt_scratch", MMIO + 32'h4, 32'd4);

        // Halting store to tohost
        load_check("tohost_rd_pre", MMIO + 32'hC, 32'd0);
        store(MMIO + 32'hC, 32'h0000_0001);
        m_halt = 1'b1;
        check("halt_done", 32'(done), 32'd1);
        check("halt_tohost", tohost, 32'd1);
        load_check("tohost_rd_done", MMIO + 32'hC, 32'd1);
        load_check("st_cnt_halt", MMIO + 32'h4, 32'd5);
        load_check("cyc_at_halt", MMIO, exp_cyc);

        // HALT: stores dropped, counters frozen, loads still served
        store(32'h00, 32'hFFFF_0000);
        store(MMIO + 32'h8, 32'h0000_0001);
        store(32'h03, 32'h0000_0003);
        repeat (5) tick();
        load_check("halt_ram_kept", 32'h00, 32'hA5A5_A5A5);
        load_check("halt_scratch_kept", MMIO + 32'h8, 32'hCAFE_0001);
        load_check("halt_st_frozen", MMIO + 32'h4, 32'd5);
        load_check("halt_cyc_frozen", MMIO, exp_cyc);
        check("halt_err_addr", err_addr, 32'h13);

        // Reset clears registers immediately but keeps RAM
        rst     = 1'b1;
        exp_cyc = 32'd0;
        m_halt  = 1'b0;
        #1;
        check("rst2_done", 32'(done), 32'd0);
        check("rst2_tohost", tohost, 32'd0);
        check("rst2_misalign", 32'(misalign_err), 32'd0);
        check("rst2_err_addr", err_addr, 32'd0);
        load_check("rst2_cyc", MMIO, 32'd0);
        load_check("rst2_st", MMIO + 32'h4, 32'd0);
        load_check("rst2_scratch", MMIO + 32'h8, 32'd0);
        load_check("rst2_ram", 32'h10, 32'hDEAD_BEEF);

        // Store coincident with reset is dropped
        store(32'h10, 32'h0BAD_F00D);
        load_check("rst_store_dropped", 32'h10, 32'hDEAD_BEEF);
        rst = 1'b0;

        // Scratch write, then asynchronous reset mid-cycle
        store(MMIO + 32'h8, 32'h0000_0055);
        tick();
        tick();
        load_check("scratch_55", MMIO + 32'h8, 32'h0000_0055);
        load_check("st_cnt_after_rst", MMIO + 32'h4, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        load_check("midrst_scratch", MMIO + 32'h8, 32'd0);
        load_check("midrst_st", MMIO + 32'h4, 32'd0);
        load_check("midrst_ram", 32'h10, 32'hDEAD_BEEF);
        check("midrst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
